// File: rtl/msrv32_pc_unit.sv
// Program-counter stage: owns the PC register and a two-state boot sequencer,
// and picks the next fetch address from boot, trap, stall, redirect or PC+4.
module msrv32_pc_unit #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic        branch_taken_in,
    input  logic [4:0]  opcode_in,
    input  logic [31:0] iadder_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_addr_in,
    input  logic        stall_in,
    output logic [31:0] i_addr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic        instr_valid_out,
    output logic        misaligned_instr_out
);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        instr_valid_q, instr_valid_d;

    logic [31:0] pc_plus_4;
    logic [31:0] redirect_target;
    logic        redirect_req;
    logic        misaligned;
    logic [31:0] next_pc;

    always_comb begin
        pc_plus_4       = pc_q + 32'd4;
        redirect_target = iadder_in & 32'hFFFF_FFFE;
        // Redirect inputs come from the instruction in execute, so they only mean something when it is valid.
        redirect_req    = instr_valid_q &&
                          ((opcode_in == OPC_JAL) ||
                           (opcode_in == OPC_JALR) ||
                           ((opcode_in == OPC_BRANCH) && branch_taken_in));

        misaligned    = 1'b0;
        next_pc       = pc_plus_4;
        state_d       = state_q;
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q;

        if (state_q == ST_BOOT) begin
            next_pc       = BOOT_ADDRESS;
            state_d       = ST_RUN;
            pc_d          = BOOT_ADDRESS;
            instr_valid_d = 1'b1;
        end else begin
            if (trap_taken_in) begin
                next_pc = trap_addr_in;
            end else if (stall_in) begin
                next_pc = pc_q;
            end else if (redirect_req) begin
                // A target with bit 1 set is reported to the trap logic and fetch continues sequentially.
                if (iadder_in[1]) begin
                    misaligned = 1'b1;
                    next_pc    = pc_plus_4;
                end else begin
                    next_pc    = redirect_target;
                end
            end
            pc_d          = next_pc;
            instr_valid_d = ~stall_in;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q       <= ST_BOOT;
            pc_q          <= BOOT_ADDRESS;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign i_addr_out           = next_pc;
    assign pc_out               = pc_q;
    assign pc_plus_4_out        = pc_plus_4;
    assign instr_valid_out      = instr_valid_q;
    assign misaligned_instr_out = misaligned;

endmodule

// File: tb/tb_msrv32_pc_unit.sv
// Scoreboarded bench for msrv32_pc_unit: each cycle pushes the expected
// registered state, which is popped and compared after the next rising edge.
module tb_msrv32_pc_unit;

    localparam logic [31:0] BOOT = 32'h0000_0100;
    localparam logic [4:0]  OP_NONE = 5'b01100;
    localparam logic [4:0]  OP_BR   = 5'b11000;
    localparam logic [4:0]  OP_JALR = 5'b11001;
    localparam logic [4:0]  OP_JAL  = 5'b11011;

    logic        clk;
    logic        rst_n;
    logic        branch_taken;
    logic [4:0]  opcode;
    logic [31:0] iadder;
    logic        trap_taken;
    logic [31:0] trap_addr;
    logic        stall;
    logic [31:0] i_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        instr_valid;
    logic        misaligned;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];
    int unsigned n_vec;
    int unsigned n_miss;

    msrv32_pc_unit #(.BOOT_ADDRESS(BOOT)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .branch_taken_in        (branch_taken),
        .opcode_in              (opcode),
        .iadder_in              (iadder),
        .trap_taken_in          (trap_taken),
        .trap_addr_in           (trap_addr),
        .stall_in               (stall),
        .i_addr_out             (i_addr),
        .pc_out                 (pc),
        .pc_plus_4_out          (pc_plus_4),
        .instr_valid_out        (instr_valid),
        .misaligned_instr_out   (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check the combinational outputs, queue the
    // expected registered state, then compare it after the rising edge.
    task automatic cyc(input string tag,
                       input logic rst, input logic trp, input logic [31:0] taddr,
                       input logic stl, input logic [4:0] op, input logic br,
                       input logic [31:0] iadd,
                       input logic [31:0] exp_iaddr, input logic exp_mis,
                       input logic [31:0] exp_pc, input logic exp_valid);
        exp_t e;
        exp_t got;
        logic [31:0] exp_p4;
        @(negedge clk);
        rst_n = rst; trap_taken = trp; trap_addr = taddr; stall = stl;
        opcode = op; branch_taken = br; iadder = iadd;
        #1;
        check({tag, ".i_addr"}, i_addr, exp_iaddr);
        check({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, exp_mis});
        e.pc = exp_pc;
        e.valid = exp_valid;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            got = exp_q.pop_front();
            exp_p4 = got.pc + 32'd4;
            check({tag, ".pc"}, pc, got.pc);
            check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, got.valid});
            check({tag, ".pc_plus_4"}, pc_plus_4, exp_p4);
        end
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        rst_n = 1'b0; trap_taken = 1'b0; trap_addr = '0; stall = 1'b0;
        opcode = OP_NONE; branch_taken = 1'b0; iadder = '0;
        @(posedge clk);
        #1;
        // reset held, noisy inputs ignored, state is BOOT
        cyc("rst1", 0, 1, 32'h800, 1, OP_JAL, 1, 32'h500, BOOT, 0, BOOT, 0);
        cyc("rst2", 0, 0, 32'h0,   0, OP_NONE, 0, 32'h0,  BOOT, 0, BOOT, 0);
        // release: BOOT cycle ignores trap/stall/jump
        cyc("boot", 1, 1, 32'h800, 1, OP_JAL, 1, 32'h502, BOOT, 0, BOOT, 1);
        cyc("seq1", 1, 0, 32'h0, 0, OP_NONE, 0, 32'h0, 32'h104, 0, 32'h104, 1);
        cyc("seq2", 1, 0, 32'h0, 0, OP_NONE, 0, 32'h0, 32'h108, 0, 32'h108, 1);
        // branches from 0x200
        cyc("trap200a", 1, 1, 32'h200, 0, OP_NONE, 0, 32'h0, 32'h200, 0, 32'h200, 1);
        cyc("br_taken", 1, 0, 32'h0, 0, OP_BR, 1, 32'h180, 32'h180, 0, 32'h180, 1);
        cyc("trap200b", 1, 1, 32'h200, 0, OP_NONE, 0, 32'h0, 32'h200, 0, 32'h200, 1);
        cyc("br_not", 1, 0, 32'h0, 0, OP_BR, 0, 32'h180, 32'h204, 0, 32'h204, 1);
        // JALR bit 0 cleared, JAL misaligned, untaken branch never flags
        cyc("jalr", 1, 0, 32'h0, 0, OP_JALR, 0, 32'h301, 32'h300, 0, 32'h300, 1);
        cyc("jal_mis", 1, 0, 32'h0, 0, OP_JAL, 0, 32'h302, 32'h304, 1, 32'h304, 1);
        cyc("br_mis_nt", 1, 0, 32'h0, 0, OP_BR, 0, 32'h302, 32'h308, 0, 32'h308, 1);
        // stall with taken branch, then trap during stall
        cyc("trap40", 1, 1, 32'h40, 0, OP_NONE, 0, 32'h0, 32'h40, 0, 32'h40, 1);
        cyc("stall1", 1, 0, 32'h0, 1, OP_BR, 1, 32'h182, 32'h40, 0, 32'h40, 0);
        cyc("stall2", 1, 0, 32'h0, 1, OP_BR, 1, 32'h182, 32'h40, 0, 32'h40, 0);
        cyc("stall_trap", 1, 1, 32'h800, 1, OP_BR, 1, 32'h180, 32'h800, 0, 32'h800, 0);
        cyc("after_trap", 1, 0, 32'h0, 0, OP_NONE, 0, 32'h0, 32'h804, 0, 32'h804, 1);
        // jump while instr_valid is low is ignored
        cyc("stall3", 1, 0, 32'h0, 1, OP_NONE, 0, 32'h0, 32'h804, 0, 32'h804, 0);
        cyc("jal_inval", 1, 0, 32'h0, 0, OP_JAL, 0, 32'h502, 32'h808, 0, 32'h808, 1);
        // wrap at top of address space
        cyc("trap_top", 1, 1, 32'hFFFF_FFFC, 0, OP_NONE, 0, 32'h0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1);
        cyc("wrap", 1, 0, 32'h0, 0, OP_NONE, 0, 32'h0, 32'h0, 0, 32'h0, 1);
        // reset mid-operation with stall and trap pending
        cyc("rst_mid", 0, 1, 32'h900, 1, OP_JAL, 0, 32'h500, 32'h900, 0, BOOT, 0);
        cyc("rst_boot", 0, 1, 32'h900, 1, OP_JAL, 0, 32'h500, BOOT, 0, BOOT, 0);
        cyc("reboot", 1, 0, 32'h0, 0, OP_NONE, 0, 32'h0, BOOT, 0, BOOT, 1);
        cyc("reseq", 1, 0, 32'h0, 0, OP_NONE, 0, 32'h0, 32'h104, 0, 32'h104, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/msrv32_pc_unit.md
# msrv32_pc_unit

Program-counter stage for the msrv32 core. It sits directly downstream of the branch unit and the immediate adder, and upstream of instruction memory. It owns the PC register and a boot sequencer, and selects the next fetch address from these sources: boot vector, trap vector, taken branch or jump target, hold on stall, or sequential PC+4. It also flags misaligned jump and branch targets to the trap logic and tells execute when the instruction-memory output is valid.

## Interface
Parameters:
- BOOT_ADDRESS, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock; all state changes on the rising edge.
- ms_riscv32_mp_rst_n_in  input  1  reset, synchronous, active-low.
- branch_taken_in  input  1  branch decision from the branch unit.
- opcode_in  input  5  instruction opcode[6:2] from decode.
- iadder_in  input  32  branch/JAL/JALR target from the immediate adder.
- trap_taken_in  input  1  trap or mret redirect request from the trap unit.
- trap_addr_in  input  32  trap vector or mepc.
- stall_in  input  1  hold request (memory not ready, or a downstream hazard).
- i_addr_out  output  32  fetch address to synchronous instruction memory (combinational next PC).
- pc_out  output  32  PC of the instruction currently in execute (registered).
- pc_plus_4_out  output  32  pc_out + 4, modulo 2^32 (combinational).
- instr_valid_out  output  1  instruction-memory data this cycle belongs to pc_out (registered).
- misaligned_instr_out  output  1  redirect target has bit 1 set (combinational).

## Operation
- States: BOOT and RUN.
- Reset, at any edge with rst_n=0 and regardless of state:
  - state <= BOOT, pc_out <= BOOT_ADDRESS, instr_valid_out <= 0.
  - Reset mid-stall or mid-redirect discards all pending requests.
- BOOT (one cycle):
  - i_addr_out = BOOT_ADDRESS; all other inputs ignored.
  - Next edge: pc_out <= BOOT_ADDRESS, instr_valid_out <= 1, state <= RUN.
- RUN: next_pc is chosen by this priority, highest first:
  1. trap_taken_in=1: trap_addr_in, taken as-is (trap unit guarantees alignment).
  2. stall_in=1: pc_out (hold and re-fetch). Branch and jump requests are ignored; decode holds its instruction, so they are re-evaluated after the stall.
  3. Redirect when instr_valid_out=1 and one of:
     - opcode_in=5'b11011 (JAL)
     - opcode_in=5'b11001 (JALR)
     - opcode_in=5'b11000 and branch_taken_in=1

     Target = {iadder_in[31:1],1'b0}. If iadder_in[1]=1: misaligned_instr_out=1, the redirect is suppressed and next_pc = pc_plus_4_out.
  4. Otherwise pc_plus_4_out.
- Redirect inputs are ignored whenever instr_valid_out=0, because they are derived from invalid instruction data.
- misaligned_instr_out is 0 outside case 3. It is never asserted during stall or trap, or in BOOT.
- In RUN, i_addr_out = next_pc. At the edge: pc_out <= next_pc, instr_valid_out <= ~stall_in. Trap has priority, so a trap during stall gives instr_valid_out <= 0, pc_out <= trap_addr_in.
- Width rules:
  - All PC arithmetic is 32-bit unsigned, wrap-around, no carry out.
  - 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - JALR bit 0 is forced to 0.

## Timing
- Instruction-memory read latency is 1 cycle. The address on i_addr_out in cycle n is reflected in pc_out and the instruction data in cycle n+1.
- Redirect latency: a request evaluated in cycle n puts the target instruction in execute in cycle n+1. No bubble and no flush are needed.
- Reset release: first edge with rst_n=1 gives BOOT to RUN. The BOOT_ADDRESS instruction is valid one cycle after reset deasserts.
- Stall: each stalled cycle holds pc_out and makes instr_valid_out 0 in the following cycle. Release resumes from the held PC with no lost or duplicated instruction.
- Reset values: pc_out=BOOT_ADDRESS, instr_valid_out=0. With state=BOOT, i_addr_out=BOOT_ADDRESS, misaligned_instr_out=0, and pc_plus_4_out=BOOT_ADDRESS+4.

## Test plan
- Boot: BOOT_ADDRESS=32'h100, hold reset 3 cycles then release.
  - Expect i_addr_out=32'h100 in BOOT.
  - Then pc_out=32'h100, instr_valid_out=1.
  - Then pc_out=32'h104, then 32'h108.
- Taken branch: pc_out=32'h200, opcode 11000, branch_taken_in=1, iadder_in=32'h180.
  - Expect i_addr_out=32'h180 and next pc_out=32'h180.
  - Same stimulus with branch_taken_in=0 gives 32'h204.
- JALR and misalignment:
  - iadder_in=32'h301 with JALR: pc_out <= 32'h300.
  - iadder_in=32'h302 with JAL: misaligned_instr_out=1, pc_out <= pc+4.
- Stall and trap collision:
  - stall_in=1 for 2 cycles at pc_out=32'h40 with a taken branch: pc_out stays 32'h40, instr_valid_out=0.
  - Assert trap_taken_in with trap_addr_in=32'h800 during the stall: pc_out=32'h800, instr_valid_out=0, then 1.
- Wrap and reset mid-operation:
  - pc_out=32'hFFFF_FFFC, no redirect: next pc_out=32'h0.
  - Assert rst_n=0 while stall_in=1 and trap_taken_in=1: pc_out=BOOT_ADDRESS, instr_valid_out=0, state BOOT.
